// File: rtl/mcb_port_cmd_arbiter.sv
// Round-robin arbiter sharing one MCB command port between up to four requesters,
// with a per-requester lock that keeps the grant for back-to-back command bursts.
module mcb_port_cmd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 30,
  parameter int BL_BITS   = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mem_calib_done,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [3*NUM_REQ-1:0]           req_instr,
  input  logic [BL_BITS*NUM_REQ-1:0]     req_bl,
  input  logic [ADDR_BITS*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           port_cmd_full,
  output logic                           port_cmd_en,
  output logic [2:0]                     port_cmd_instr,
  output logic [BL_BITS-1:0]             port_cmd_bl,
  output logic [ADDR_BITS-1:0]           port_cmd_byte_addr,
  output logic                           busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [PTR_W-1:0]   g_idx_r, g_idx_nxt_s;
  logic [NUM_REQ-1:0] grant_nxt_s, ack_nxt_s;
  logic               en_nxt_s, load_s;
  logic [PTR_W:0]     pick_s;

  // Returns {found, index} of the first requester at or after the pointer.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [PTR_W-1:0]   p);
    logic [PTR_W:0]   pick;
    logic [PTR_W-1:0] c;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = PTR_W'((int'(p) + k) % NUM_REQ);
      if (r[c]) pick = {1'b1, c};
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] i);
    return PTR_W'((int'(i) + 1) % NUM_REQ);
  endfunction

  // Next-state and next-output decode.
  always_comb begin
    pick_s       = rr_pick(req, rr_ptr_r);
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    g_idx_nxt_s  = g_idx_r;
    grant_nxt_s  = grant;
    ack_nxt_s    = '0;
    en_nxt_s     = 1'b0;
    load_s       = 1'b0;
    if (!mem_calib_done) begin
      state_nxt_s = ST_IDLE;
      grant_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_ARB;
        end
        ST_ARB: begin
          // The ack cycle is skipped so a requester's stale req is never re-granted.
          if (pick_s[PTR_W] && (ack == '0)) begin
            g_idx_nxt_s = pick_s[PTR_W-1:0];
            grant_nxt_s = onehot(pick_s[PTR_W-1:0]);
            load_s      = 1'b1;
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_ARB;
          end
        end
        ST_ISSUE: begin
          if (!port_cmd_full) begin
            en_nxt_s  = 1'b1;
            ack_nxt_s = onehot(g_idx_r);
            if (lock[g_idx_r]) begin
              state_nxt_s = ST_HOLD;
            end else begin
              state_nxt_s  = ST_ARB;
              rr_ptr_nxt_s = next_ptr(g_idx_r);
              grant_nxt_s  = '0;
            end
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end
        ST_HOLD: begin
          if (req[g_idx_r]) begin
            load_s      = 1'b1;
            state_nxt_s = ST_ISSUE;
          end else if (!lock[g_idx_r]) begin
            state_nxt_s  = ST_ARB;
            rr_ptr_nxt_s = next_ptr(g_idx_r);
            grant_nxt_s  = '0;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = '0;
        end
      endcase
    end
  end

  // State, pointer and registered port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r            <= ST_IDLE;
      rr_ptr_r           <= '0;
      g_idx_r            <= '0;
      grant              <= '0;
      ack                <= '0;
      port_cmd_en        <= 1'b0;
      port_cmd_instr     <= 3'd0;
      port_cmd_bl        <= '0;
      port_cmd_byte_addr <= '0;
      busy               <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      g_idx_r     <= g_idx_nxt_s;
      grant       <= grant_nxt_s;
      ack         <= ack_nxt_s;
      port_cmd_en <= en_nxt_s;
      busy        <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_HOLD);
      if (load_s) begin
        port_cmd_instr     <= req_instr[3*g_idx_nxt_s +: 3];
        port_cmd_bl        <= req_bl[BL_BITS*g_idx_nxt_s +: BL_BITS];
        port_cmd_byte_addr <= req_addr[ADDR_BITS*g_idx_nxt_s +: ADDR_BITS];
      end
    end
  end

endmodule

// File: tb/tb_mcb_port_cmd_arbiter.sv
// Directed-vector bench for mcb_port_cmd_arbiter: single command, round robin,
// backpressure, lock bursts, calibration loss and asynchronous reset.
module tb_mcb_port_cmd_arbiter;

  logic         c3_clk0 = 1'b0;
  logic         reset = 1'b1;
  logic         mem_calib_done = 1'b0;
  logic [3:0]   req = 4'b0;
  logic [3:0]   lock = 4'b0;
  logic [11:0]  req_instr = 12'b0;
  logic [23:0]  req_bl = 24'b0;
  logic [119:0] req_addr = 120'b0;
  logic         port_cmd_full = 1'b0;
  logic [3:0]   grant, ack;
  logic         port_cmd_en, busy;
  logic [2:0]   port_cmd_instr;
  logic [5:0]   port_cmd_bl;
  logic [29:0]  port_cmd_byte_addr;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic [3:0]  ack_q[$];
  logic [29:0] addr_q[$];
  int          en_cyc_q[$];
  logic [29:0] burst_a [3] = '{30'd0, 30'd2560, 30'd5120};

  mcb_port_cmd_arbiter #(.NUM_REQ(4), .ADDR_BITS(30), .BL_BITS(6)) dut (
    .clk(c3_clk0), .reset(reset), .mem_calib_done(mem_calib_done),
    .req(req), .lock(lock), .req_instr(req_instr), .req_bl(req_bl),
    .req_addr(req_addr), .grant(grant), .ack(ack),
    .port_cmd_full(port_cmd_full), .port_cmd_en(port_cmd_en),
    .port_cmd_instr(port_cmd_instr), .port_cmd_bl(port_cmd_bl),
    .port_cmd_byte_addr(port_cmd_byte_addr), .busy(busy)
  );

  always #5 c3_clk0 = ~c3_clk0;

  always @(posedge c3_clk0) cyc <= cyc + 1;

  // Log every strobe and ack away from the active edge.
  always @(negedge c3_clk0) begin
    if (port_cmd_en) begin
      en_cyc_q.push_back(cyc);
      addr_q.push_back(port_cmd_byte_addr);
    end
    if (ack != 4'b0) ack_q.push_back(ack);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge c3_clk0);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs;
    ack_q.delete();
    addr_q.delete();
    en_cyc_q.delete();
  endtask

  task automatic set_cmd(input int i, input logic [2:0] ins, input logic [5:0] b, input logic [29:0] a);
    req_instr[3*i +: 3] = ins;
    req_bl[6*i +: 6]    = b;
    req_addr[30*i +: 30] = a;
  endtask

  // Each requester drops its req in the cycle its ack is seen.
  task automatic serve(input string tag);
    int n = 0;
    while (req != 4'b0 && n < 60) begin
      tick;
      req = req & ~ack;
      n++;
    end
    check_vec({tag, "_done"}, 64'(req), 64'h0);
    repeat (3) tick;
  endtask

  task automatic check_order(input string tag, input logic [15:0] exp, input int n);
    check_vec({tag, "_count"}, 64'(ack_q.size()), 64'(n));
    for (int i = 0; i < n; i++)
      check_vec(tag, 64'((i < ack_q.size()) ? ack_q[i] : 4'h0), 64'(exp[4*i +: 4]));
  endtask

  initial begin
    repeat (2) tick;
    check_vec("rst_grant", 64'(grant), 64'h0);
    check_vec("rst_ack", 64'(ack), 64'h0);
    check_vec("rst_en", 64'(port_cmd_en), 64'h0);
    check_vec("rst_fields", 64'({port_cmd_instr, port_cmd_bl, port_cmd_byte_addr}), 64'h0);
    check_vec("rst_busy", 64'(busy), 64'h0);
    #2 reset = 1'b0;
    mem_calib_done = 1'b1;
    tick;
    check_vec("arb_idle_busy", 64'(busy), 64'h0);

    // Round robin over all four, then 0 before 3 with pointer at 0.
    clear_logs();
    for (int i = 0; i < 4; i++) set_cmd(i, 3'b000, 6'(i), 30'(16 * i));
    req = 4'b1111;
    serve("rr4");
    check_order("rr4_order", 16'h8421, 4);
    check_vec("rr_spacing", 64'(en_cyc_q.size() > 1 ? en_cyc_q[1] - en_cyc_q[0] : 0), 64'd3);
    clear_logs();
    req = 4'b1001;
    serve("pair0");
    check_order("pair0_order", 16'h0081, 2);

    // Single command latency and fields; pointer ends at 2.
    clear_logs();
    set_cmd(1, 3'b001, 6'd31, 30'h500);
    req = 4'b0010;
    tick;
    check_vec("single_grant", 64'(grant), 64'h2);
    check_vec("single_en_early", 64'(port_cmd_en), 64'h0);
    check_vec("single_busy", 64'(busy), 64'h1);
    tick;
    check_vec("single_en", 64'(port_cmd_en), 64'h1);
    check_vec("single_ack", 64'(ack), 64'h2);
    check_vec("single_instr", 64'(port_cmd_instr), 64'h1);
    check_vec("single_bl", 64'(port_cmd_bl), 64'd31);
    check_vec("single_addr", 64'(port_cmd_byte_addr), 64'h500);
    req = 4'b0;
    repeat (3) tick;
    check_vec("single_strobes", 64'(en_cyc_q.size()), 64'd1);
    check_vec("single_grant_clr", 64'(grant), 64'h0);
    check_vec("single_busy_clr", 64'(busy), 64'h0);

    // Pointer at 2: requester 3 wins over 0.
    clear_logs();
    req = 4'b1001;
    serve("pair2");
    check_order("pair2_order", 16'h0018, 2);

    // Backpressure: fields captured once and held while the FIFO is full.
    clear_logs();
    set_cmd(2, 3'b000, 6'd15, 30'h1234);
    port_cmd_full = 1'b1;
    req = 4'b0100;
    tick;
    check_vec("bp_grant", 64'(grant), 64'h4);
    set_cmd(2, 3'b011, 6'd7, 30'h3FFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      tick;
      check_vec("bp_no_en", 64'(port_cmd_en), 64'h0);
      check_vec("bp_fields", 64'({port_cmd_instr, port_cmd_bl, port_cmd_byte_addr}),
                64'({3'b000, 6'd15, 30'h1234}));
    end
    port_cmd_full = 1'b0;
    tick;
    check_vec("bp_en", 64'(port_cmd_en), 64'h1);
    check_vec("bp_ack", 64'(ack), 64'h4);
    req = 4'b0;
    repeat (3) tick;
    check_vec("bp_strobes", 64'(en_cyc_q.size()), 64'd1);
    check_vec("bp_acks", 64'(ack_q.size()), 64'd1);

    // Lock burst by requester 2 while requester 0 waits.
    clear_logs();
    set_cmd(0, 3'b001, 6'd3, 30'h40);
    set_cmd(2, 3'b000, 6'd63, burst_a[0]);
    req = 4'b0100;
    lock = 4'b0100;
    tick;
    check_vec("lock_grant", 64'(grant), 64'h4);
    req[0] = 1'b1;
    begin
      int k = 0;
      int n = 0;
      while (req != 4'b0 && n < 60) begin
        tick;
        if (ack[2]) begin
          k++;
          if (k < 3) req_addr[60 +: 30] = burst_a[k];
          else begin
            req[2] = 1'b0;
            lock[2] = 1'b0;
          end
        end
        if (ack[0]) req[0] = 1'b0;
        n++;
      end
    end
    check_vec("lock_done", 64'(req), 64'h0);
    repeat (3) tick;
    check_order("lock_order", 16'h1444, 4);
    if (addr_q.size() == 4) begin
      check_vec("lock_addr0", 64'(addr_q[0]), 64'd0);
      check_vec("lock_addr1", 64'(addr_q[1]), 64'd2560);
      check_vec("lock_addr2", 64'(addr_q[2]), 64'd5120);
      check_vec("lock_addr3", 64'(addr_q[3]), 64'h40);
      check_vec("lock_gap1", 64'(en_cyc_q[1] - en_cyc_q[0]), 64'd2);
      check_vec("lock_gap2", 64'(en_cyc_q[2] - en_cyc_q[1]), 64'd2);
      check_vec("lock_gap3", 64'(en_cyc_q[3] - en_cyc_q[2]), 64'd3);
    end else begin
      check_vec("lock_strobes", 64'(addr_q.size()), 64'd4);
    end

    // Calibration loss while stuck in ISSUE.
    clear_logs();
    set_cmd(1, 3'b010, 6'd1, 30'h777);
    port_cmd_full = 1'b1;
    req = 4'b0010;
    tick;
    check_vec("cal_grant", 64'(grant), 64'h2);
    tick;
    mem_calib_done = 1'b0;
    tick;
    check_vec("cal_grant_clr", 64'(grant), 64'h0);
    check_vec("cal_busy", 64'(busy), 64'h0);
    check_vec("cal_en", 64'(port_cmd_en), 64'h0);
    tick;
    check_vec("cal_idle_grant", 64'(grant), 64'h0);
    mem_calib_done = 1'b1;
    port_cmd_full = 1'b0;
    tick;
    check_vec("cal_arb_grant", 64'(grant), 64'h0);
    tick;
    check_vec("cal_regrant", 64'(grant), 64'h2);
    tick;
    check_vec("cal_en_resume", 64'(port_cmd_en), 64'h1);
    check_vec("cal_addr", 64'(port_cmd_byte_addr), 64'h777);
    req = 4'b0;
    repeat (3) tick;
    check_vec("cal_acks", 64'(ack_q.size()), 64'd1);

    // Asynchronous reset in the middle of a HOLD.
    clear_logs();
    set_cmd(3, 3'b001, 6'd0, 30'h999);
    req = 4'b1000;
    lock = 4'b1000;
    repeat (2) tick;
    check_vec("hold_ack", 64'(ack), 64'h8);
    req = 4'b0;
    repeat (2) tick;
    check_vec("hold_grant", 64'(grant), 64'h8);
    check_vec("hold_busy", 64'(busy), 64'h1);
    #2 reset = 1'b1;
    #1;
    check_vec("arst_outputs", 64'({grant, ack, port_cmd_en, busy, port_cmd_byte_addr}), 64'h0);
    #3 reset = 1'b0;
    lock = 4'b0;
    tick;
    clear_logs();
    req = 4'b1001;
    serve("post_rst");
    check_order("post_rst_order", 16'h0081, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mcb_port_cmd_arbiter.md
Name: mcb_port_cmd_arbiter

Overview:
Round-robin arbiter that shares one DDR2 MCB port command path (cmd_en/instr/bl/byte_addr) between up to four requesters. Typical requesters are the line-read dispatcher, the HDMI video writer and the motion-segmentation background reader/writer. It sits between those units and one c3_pX_cmd_* port of ddr2_user_interface, in the c3_clk0 domain. It also supports a lock so that one requester can issue a burst of back-to-back commands, for example one full video line, without interleaving.

Parameters:
NUM_REQ, 4, number of requesters (2..4)
ADDR_BITS, 30, MCB byte address width
BL_BITS, 6, MCB burst length field width

Ports:
clk  in  1  memory-side clock (c3_clk0)
reset  in  1  asynchronous, active-high reset
mem_calib_done  in  1  MCB calibration complete
req  in  NUM_REQ  per-requester command request
lock  in  NUM_REQ  per-requester hold-grant request
req_instr  in  3*NUM_REQ  requester i at [3i+:3]
req_bl  in  BL_BITS*NUM_REQ  requester i at [BL_BITS*i+:BL_BITS]
req_addr  in  ADDR_BITS*NUM_REQ  requester i at [ADDR_BITS*i+:ADDR_BITS]
grant  out  NUM_REQ  one-hot current owner
ack  out  NUM_REQ  one-cycle pulse: command accepted into MCB
port_cmd_full  in  1  MCB cmd FIFO full
port_cmd_en  out  1  MCB command strobe
port_cmd_instr  out  3  MCB instruction
port_cmd_bl  out  BL_BITS  MCB burst length minus 1
port_cmd_byte_addr  out  ADDR_BITS  MCB byte address
busy  out  1  state != ARB and != IDLE

Behaviour:
- Reset values and outputs:
  - All outputs are registered.
  - On reset: grant=0, ack=0, port_cmd_en=0, instr/bl/addr=0, busy=0, state=IDLE, rr_ptr=0.
- IDLE: wait for mem_calib_done=1, then go to ARB.
- calib_done loss: mem_calib_done=0 in any state forces IDLE next cycle. grant clears, no ack is issued, and a pending command is dropped.
- ARB:
  - If any req is high, select the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Next cycle: grant one-hot, and that requester's instr/bl/addr are latched into the output registers. Go to ISSUE.
  - No req: stay in ARB.
- ISSUE:
  - port_cmd_full=0 at the clock edge: next cycle port_cmd_en=1 and ack[g]=1 for exactly one cycle, with the latched fields.
  - If lock[g]=1 at that edge, go to HOLD. Otherwise go to ARB, set rr_ptr=g+1 mod NUM_REQ and clear grant.
  - port_cmd_full=1: stay in ISSUE, port_cmd_en=0, fields held stable.
- HOLD: grant stays g and other requests are ignored.
  - req[g]=1: latch fields, go to ISSUE.
  - lock[g]=0 and req[g]=0: go to ARB, set rr_ptr=g+1, clear grant.
  - req[g] and lock[g] fall together: take the release path, no issue.
- Latency: req sampled in ARB at edge 0 → grant at cycle 1 → port_cmd_en and ack at cycle 2 (no backpressure). Minimum spacing between commands is 3 cycles from unlocked ARB and 2 cycles inside HOLD.
- Requester contract:
  - Hold req and fields stable until ack.
  - req must be low in the cycle after ack unless a new command is intended.
  - Write data must already be in the MCB write FIFO before req for write instructions; the arbiter does not touch the data path.
- Fields are captured once per command. Changes to req_* after capture are ignored until the next ack.
- Requests from non-granted requesters stay pending; they are never lost or acked.
- Unused req bits when NUM_REQ<4 do not exist. rr_ptr width is clog2(NUM_REQ).

Test Plan:
- Single request: calib_done=1, req[1]=1, instr=3'b001, bl=31, addr=0x500 → grant=4'b0010 at cycle 1; port_cmd_en and ack[1] at cycle 2 with instr=1, bl=31, addr=0x500; exactly one strobe.
- Round robin: req=4'b1111 held, each dropped the cycle after its ack → ack order 0,1,2,3. Then re-assert req[0] and req[3] with rr_ptr=0 → 0 before 3. With rr_ptr=2 → 3 before 0.
- Backpressure: port_cmd_full=1 for 5 cycles during ISSUE → no port_cmd_en, fields stable. Full deasserts → one port_cmd_en one cycle later, ack once.
- Lock burst: lock[2]=1 with 3 sequential commands at addrs 0, 2560, 5120 while req[0]=1 → three consecutive requester-2 commands 2 cycles apart. Requester 0 is granted only after lock[2] falls.
- Calib loss: drop mem_calib_done while in ISSUE with port_cmd_full=1 → IDLE next cycle, grant=0, no ack. Restore calib → arbitration resumes with req still high.
- Async reset mid-HOLD → all outputs 0 immediately without a clock edge. After release, rr_ptr=0 and the first request is served from requester 0 priority.
